tpu_mac_array: RTL and testbench

- Parametrised, handshaked successor to the fixed 4-lane TPU datapath.
- Holds an N x N weight matrix stationary and streams K input vectors through a pipelined multiply/column-sum stage.
- Accumulates acc[j] = sum over k and i of x_k[i] * W[i][j], then presents the result with a valid/ready output handshake.
- Sits between the operand buffers and the result writeback path.

---
 rtl/tpu_pkg.sv | 60 ++++++
 rtl/tpu_mac_column.sv | 95 +++++++++
 rtl/tpu_mac_array.sv | 141 ++++++++++++++
 tb/tb_tpu_mac_array.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared types and helpers for the weight-stationary MAC array.
// State encoding, drain length, saturating add and width legality.
package tpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_COMPUTE,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam int unsigned DRAIN_CYCLES = 2;

  // Working width for saturation math; accumulators must be narrower.
  localparam int unsigned SAT_W = 64;

  // Smallest accumulator that holds one full column sum without wrap.
  function automatic int unsigned acc_min_width(
    input int unsigned n,
    input int unsigned dw
  );
    return 2 * dw + $clog2(n);
  endfunction

  // Add two pre-extended operands and clamp to a w-bit range.
  function automatic logic [SAT_W-1:0] sat_add(
    input  logic [SAT_W-1:0] a,
    input  logic [SAT_W-1:0] b,
    input  int unsigned      w,
    input  logic             sgn,
    output logic             ovf
  );
    logic signed [SAT_W-1:0] s;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    logic [SAT_W-1:0]        one;
    logic [SAT_W-1:0]        res;
    one = SAT_W'(1);
    s   = $signed(a + b);
    if (sgn) begin
      hi = $signed((one << (w - 1)) - one);
      lo = ~hi;
    end else begin
      hi = $signed((one << w) - one);
      lo = '0;
    end
    ovf = 1'b0;
    res = s;
    if (s > hi) begin
      ovf = 1'b1;
      res = hi;
    end else if (s < lo) begin
      ovf = 1'b1;
      res = lo;
    end
    return res;
  endfunction

endpackage

// File: rtl/tpu_mac_column.sv
// One output column: N multipliers, column adder, saturating accumulator.
// Products and sums are pipelined; the accumulate lands two edges after accept.
module tpu_mac_column
  import tpu_pkg::*;
#(
  parameter int unsigned N          = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 24
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr_i,
  input  logic                      sgn_i,
  input  logic                      en_i,
  input  logic [N*DATA_WIDTH-1:0]   x_i,
  input  logic [N*DATA_WIDTH-1:0]   w_i,
  output logic [ACC_WIDTH-1:0]      acc_o,
  output logic                      ovf_o
);

  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned AW = ACC_WIDTH;
  localparam int unsigned PW = 2 * DW;

  logic [N-1:0][PW-1:0] prod_d;
  logic [N-1:0][PW-1:0] prod_q;
  logic [AW-1:0]        sum_d;
  logic [AW-1:0]        sum_q;
  logic [AW-1:0]        acc_d;
  logic [AW-1:0]        acc_q;
  logic                 sat_ovf;
  logic                 ovf_q;
  logic                 v1_q;
  logic                 v2_q;
  logic [SAT_W-1:0]     acc_x;
  logic [SAT_W-1:0]     sum_x;

  // Stage-1 products: one extra bit lets one signed multiply serve both modes.
  always_comb begin
    logic signed [DW:0] xe;
    logic signed [DW:0] we;
    prod_d = '0;
    for (int i = 0; i < N; i++) begin
      xe = {sgn_i & x_i[i*DW+DW-1], x_i[i*DW +: DW]};
      we = {sgn_i & w_i[i*DW+DW-1], w_i[i*DW +: DW]};
      prod_d[i] = PW'(xe * we);
    end
  end

  // Stage-2 column sum, each product extended to accumulator width.
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < N; i++) begin
      if (sgn_i)
        sum_d = sum_d + {{(AW-PW){prod_q[i][PW-1]}}, prod_q[i]};
      else
        sum_d = sum_d + {{(AW-PW){1'b0}}, prod_q[i]};
    end
  end

  // Stage-3 saturating accumulate in a wide signed domain.
  always_comb begin
    acc_x = {{(SAT_W-AW){sgn_i & acc_q[AW-1]}}, acc_q};
    sum_x = {{(SAT_W-AW){sgn_i & sum_q[AW-1]}}, sum_q};
    acc_d = AW'(sat_add(acc_x, sum_x, AW, sgn_i, sat_ovf));
  end

  // Pipeline registers and the sticky per-column overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
      sum_q  <= '0;
      acc_q  <= '0;
      ovf_q  <= 1'b0;
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
    end else begin
      v1_q <= en_i;
      v2_q <= v1_q;
      if (en_i) prod_q <= prod_d;
      if (v1_q) sum_q  <= sum_d;
      if (clr_i) begin
        acc_q <= '0;
        ovf_q <= 1'b0;
      end else if (v2_q) begin
        acc_q <= acc_d;
        ovf_q <= ovf_q | sat_ovf;
      end
    end
  end

  assign acc_o = acc_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/tpu_mac_array.sv
// Weight-stationary N x N MAC array with job FSM and valid/ready handshakes.
// Loads W row by row, streams K vectors, drains, then presents column sums.
module tpu_mac_array
  import tpu_pkg::*;
#(
  parameter int unsigned N          = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 24,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [CNT_WIDTH-1:0]      vec_count,
  input  logic                      signed_mode,
  input  logic                      wt_valid,
  output logic                      wt_ready,
  input  logic [N*DATA_WIDTH-1:0]   wt_row,
  input  logic                      x_valid,
  output logic                      x_ready,
  input  logic [N*DATA_WIDTH-1:0]   x_vec,
  output logic [N*ACC_WIDTH-1:0]    acc_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      overflow
);

  localparam int unsigned DW  = DATA_WIDTH;
  localparam int unsigned RW  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned DRW = $clog2(DRAIN_CYCLES + 1);

  if (ACC_WIDTH < acc_min_width(N, DATA_WIDTH) || ACC_WIDTH >= SAT_W) begin : g_bad_acc
    $error("tpu_mac_array: ACC_WIDTH too small for N and DATA_WIDTH");
  end

  state_e                    state_q;
  state_e                    state_d;
  logic [RW-1:0]             row_q;
  logic [CNT_WIDTH-1:0]      rem_q;
  logic [DRW-1:0]            drn_q;
  logic                      sgn_q;
  logic [N-1:0][N*DW-1:0]    w_q;
  logic [N-1:0][N*DW-1:0]    w_col;
  logic [N-1:0][ACC_WIDTH-1:0] acc_col;
  logic [N-1:0]              ovf_col;
  logic                      job_go;
  logic                      wt_fire;
  logic                      x_fire;
  logic                      out_fire;
  logic                      last_row;

  assign job_go   = start && (state_q == S_IDLE);
  assign wt_fire  = wt_valid && wt_ready;
  assign x_fire   = x_valid && x_ready;
  assign out_fire = out_valid && out_ready;
  assign last_row = (row_q == RW'(N - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; drain holds until the last accumulate has settled.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (start) state_d = S_LOAD_W;
      S_LOAD_W:  if (wt_fire && last_row)
                   state_d = (rem_q == '0) ? S_DONE : S_COMPUTE;
      S_COMPUTE: if (x_fire && rem_q == CNT_WIDTH'(1)) state_d = S_DRAIN;
      S_DRAIN:   if (drn_q == DRW'(DRAIN_CYCLES)) state_d = S_DONE;
      S_DONE:    if (out_fire) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from state.
  always_comb begin
    wt_ready  = (state_q == S_LOAD_W);
    x_ready   = (state_q == S_COMPUTE) && (rem_q != '0);
    out_valid = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
  end

  // Job counters, latched mode and weight storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      rem_q <= '0;
      drn_q <= '0;
      sgn_q <= 1'b0;
      w_q   <= '0;
    end else begin
      if (job_go) begin
        row_q <= '0;
        rem_q <= vec_count;
        sgn_q <= signed_mode;
      end else begin
        if (wt_fire) begin
          w_q[row_q] <= wt_row;
          row_q      <= row_q + 1'b1;
        end
        if (x_fire) rem_q <= rem_q - 1'b1;
      end
      if (state_q == S_DRAIN) drn_q <= drn_q + 1'b1;
      else                    drn_q <= '0;
    end
  end

  // Transpose stored rows so each column sees W[0..N-1][j].
  always_comb begin
    w_col = '0;
    for (int j = 0; j < N; j++)
      for (int i = 0; i < N; i++)
        w_col[j][i*DW +: DW] = w_q[i][j*DW +: DW];
  end

  for (genvar j = 0; j < N; j++) begin : g_col
    tpu_mac_column #(
      .N          (N),
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH)
    ) u_col (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (job_go),
      .sgn_i (sgn_q),
      .en_i  (x_fire),
      .x_i   (x_vec),
      .w_i   (w_col[j]),
      .acc_o (acc_col[j]),
      .ovf_o (ovf_col[j])
    );
  end

  assign acc_out  = acc_col;
  assign overflow = |ovf_col;

endmodule

// File: tb/tb_tpu_mac_array.sv
// Randomised and directed bench for tpu_mac_array.
// A plain-arithmetic model predicts each job; a monitor checks DONE outputs.
module tb_tpu_mac_array;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 24;
  localparam int CW = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [CW-1:0]   vec_count = '0;
  logic            signed_mode = 1'b0;
  logic            wt_valid = 1'b0;
  logic            wt_ready;
  logic [N*DW-1:0] wt_row = '0;
  logic            x_valid = 1'b0;
  logic            x_ready;
  logic [N*DW-1:0] x_vec = '0;
  logic [N*AW-1:0] acc_out;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic            busy;
  logic            overflow;

  tpu_mac_array #(
    .N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .vec_count(vec_count), .signed_mode(signed_mode),
    .wt_valid(wt_valid), .wt_ready(wt_ready), .wt_row(wt_row),
    .x_valid(x_valid), .x_ready(x_ready), .x_vec(x_vec),
    .acc_out(acc_out), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] wm [N][N];
  logic [7:0] xv [100][N];
  longint     exp_acc [N];
  bit         exp_ovf;
  bit         mon_en = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic longint m24(input longint v);
    return v & 64'hFF_FFFF;
  endfunction

  function automatic longint ev(input logic [7:0] b, input bit sg);
    if (sg) return longint'($signed(b));
    return longint'(b);
  endfunction

  function automatic longint col(input int j);
    return longint'(acc_out[j*AW +: AW]);
  endfunction

  // Expected job result: per-vector column dot products, clamped each step.
  task automatic model(input int k, input bit sg);
    longint mx, mn, cs, s;
    mx = sg ? 64'sd8388607 : 64'sd16777215;
    mn = sg ? -64'sd8388608 : 64'sd0;
    for (int j = 0; j < N; j++) exp_acc[j] = 0;
    exp_ovf = 1'b0;
    for (int kk = 0; kk < k; kk++)
      for (int j = 0; j < N; j++) begin
        cs = 0;
        for (int i = 0; i < N; i++) cs += ev(xv[kk][i], sg) * ev(wm[i][j], sg);
        s = exp_acc[j] + cs;
        if (s > mx) begin s = mx; exp_ovf = 1'b1; end
        if (s < mn) begin s = mn; exp_ovf = 1'b1; end
        exp_acc[j] = s;
      end
  endtask

  // Every cycle the result is offered it must match the model.
  always @(negedge clk) begin
    if (mon_en && rst_n && out_valid) begin
      for (int j = 0; j < N; j++)
        chk($sformatf("mon_col%0d", j), col(j), m24(exp_acc[j]));
      chk("mon_ovf", overflow, exp_ovf);
      chk("mon_busy", busy, 1);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_job(input int k, input bit sg, output int ta);
    int n;
    start = 1'b1;
    vec_count = CW'(k);
    signed_mode = sg;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) wt_row[j*DW +: DW] = wm[i][j];
      wt_valid = 1'b1;
      n = 0;
      while (!wt_ready && n < 50) begin tick(); n++; end
      if (n >= 50) chk("wt_ready_timeout", 0, 1);
      tick();
      wt_valid = 1'b0;
    end
    ta = cyc;
  endtask

  task automatic send_vec(input int kk, input int gap, output int ta);
    int n;
    repeat (gap) tick();
    for (int i = 0; i < N; i++) x_vec[i*DW +: DW] = xv[kk][i];
    x_valid = 1'b1;
    n = 0;
    while (!x_ready && n < 50) begin tick(); n++; end
    if (n >= 50) chk("x_ready_timeout", 0, 1);
    tick();
    ta = cyc;
    x_valid = 1'b0;
  endtask

  task automatic run_job(input int k, input bit sg, input int gap,
                         input int bp, input bit poke);
    int n, ta, g;
    logic [N*AW-1:0] hold;
    model(k, sg);
    mon_en = 1'b1;
    load_job(k, sg, ta);
    for (int kk = 0; kk < k; kk++) begin
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      send_vec(kk, g, ta);
      if (poke && kk == 0 && k > 1) begin
        start = 1'b1;
        vec_count = CW'(7);
        tick();
        start = 1'b0;
        chk("start_ignored_xready", x_ready, 1);
      end
    end
    if (k > 0) chk("x_ready_after_last", x_ready, 0);
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    if (n >= 20) chk("out_valid_timeout", 0, 1);
    chk("latency", cyc - ta, (k > 0) ? 3 : 0);
    hold = acc_out;
    repeat (bp) begin
      tick();
      chk("bp_valid", out_valid, 1);
      chk("bp_stable", acc_out == hold, 1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    mon_en = 1'b0;
    chk("idle_busy", busy, 0);
    chk("idle_out_valid", out_valid, 0);
  endtask

  task automatic lit(input string nm, input longint base, input bit ov);
    for (int j = 0; j < N; j++)
      chk($sformatf("%s_col%0d", nm, j), col(j), m24(base * (j + 1)));
    chk({nm, "_ovf"}, overflow, ov);
  endtask

  task automatic chk_zero_outs(input string nm);
    chk({nm, "_acc"}, acc_out == '0, 1);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_wt_ready"}, wt_ready, 0);
    chk({nm, "_x_ready"}, x_ready, 0);
    chk({nm, "_out_valid"}, out_valid, 0);
    chk({nm, "_ovf"}, overflow, 0);
  endtask

  task automatic basic_w;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) wm[i][j] = 8'(10 * (j + 1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=hang required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ta;
    rst_n = 1'b0;
    tick();
    tick();
    chk_zero_outs("reset");
    rst_n = 1'b1;
    tick();

    basic_w();
    for (int i = 0; i < N; i++) xv[0][i] = 8'(i + 1);
    run_job(1, 1'b0, 0, 0, 1'b0);
    lit("basic", 100, 1'b0);

    for (int k = 0; k < 3; k++)
      for (int i = 0; i < N; i++) xv[k][i] = 8'(i + 1);
    run_job(3, 1'b0, 2, 0, 1'b1);
    lit("multi", 300, 1'b0);

    for (int i = 0; i < N; i++) xv[0][i] = 8'(8'hFF - i);
    run_job(1, 1'b1, 0, 0, 1'b0);
    lit("signed", -100, 1'b0);
    run_job(1, 1'b0, 0, 0, 1'b0);
    lit("unsigned", 10140, 1'b0);

    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) wm[i][j] = 8'hFF;
    for (int k = 0; k < 65; k++)
      for (int i = 0; i < N; i++) xv[k][i] = 8'hFF;
    run_job(64, 1'b0, 0, 0, 1'b0);
    for (int j = 0; j < N; j++) chk("sat64", col(j), 16646400);
    chk("sat64_ovf", overflow, 0);
    run_job(65, 1'b0, 0, 0, 1'b0);
    for (int j = 0; j < N; j++) chk("sat65", col(j), 16777215);
    chk("sat65_ovf", overflow, 1);

    basic_w();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++) xv[k][i] = 8'(i + 1);
    run_job(2, 1'b0, 1, 5, 1'b0);
    lit("backpressure", 200, 1'b0);

    run_job(0, 1'b0, 0, 2, 1'b0);
    lit("kzero", 0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      int k;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) wm[i][j] = 8'($urandom);
      k = int'($urandom_range(1, 8));
      for (int kk = 0; kk < k; kk++)
        for (int i = 0; i < N; i++) xv[kk][i] = 8'($urandom);
      run_job(k, 1'($urandom), -1, int'($urandom_range(0, 3)), 1'b0);
    end

    basic_w();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < N; i++) xv[k][i] = 8'(i + 1);
    load_job(3, 1'b0, ta);
    send_vec(0, 0, ta);
    send_vec(1, 0, ta);
    tick();
    tick();
    tick();
    chk("pre_reset_compute", x_ready, 1);
    #2 rst_n = 1'b0;
    #1;
    chk_zero_outs("midreset");
    tick();
    rst_n = 1'b1;
    tick();
    run_job(1, 1'b0, 0, 0, 1'b0);
    lit("after_reset", 100, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
